cipher_out_serializer: RTL and testbench

//   Consumes the registered 128-bit ciphertext from the final encryption round (round 10).

---
 rtl/cipher_out_serializer.sv | 113 +++++++++++
 tb/tb_cipher_out_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cipher_out_serializer.sv
// cipher_out_serializer
//   Takes the 128-bit ciphertext block from the round-10 stage and buffers whole
//   blocks in a small FIFO. It sends each block out, most significant word first,
//   as WORD_WIDTH-bit words on a valid/ready stream. The AES pipeline cannot
//   stall, so an arriving block is dropped when the FIFO is full and nothing
//   leaves it in that cycle. Each drop sets the sticky OVERFLOW flag.
// Ports
//   clk, rst       clock; asynchronous active-low reset
//   IN_VALID, IN   new ciphertext block (IN is ignored when IN_VALID=0)
//   CLR_OVF        synchronous clear of OVERFLOW (a drop in the same cycle wins)
//   WORD_OUT       current output word, qualified by WORD_VALID
//   WORD_VALID     a word is available
//   WORD_READY     downstream accepts the word this cycle
//   LAST           WORD_OUT is the final word of its block
//   OVERFLOW       sticky: at least one block was dropped
//   LEVEL          blocks held, including one that is partly sent
module cipher_out_serializer #(
  parameter int BLOCK_LENGTH = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  localparam int N  = BLOCK_LENGTH / WORD_WIDTH,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IN_VALID,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic                    CLR_OVF,
  output logic [WORD_WIDTH-1:0]   WORD_OUT,
  output logic                    WORD_VALID,
  input  logic                    WORD_READY,
  output logic                    LAST,
  output logic                    OVERFLOW,
  output logic [LW-1:0]           LEVEL
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state, state_nxt;
  logic [BLOCK_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           head, tail;
  logic [IW-1:0]           idx;
  logic [LW-1:0]           level;
  logic                    ovf;

  logic                    xfer, pop, push, drop, full;
  logic [BLOCK_LENGTH-1:0] head_blk;
  logic [WORD_WIDTH-1:0]   words [N];

  // The head block is split into words in output order (MSW = word 0). The
  // output is a mux on registered state only, so it stays stable under stall.
  assign head_blk = mem[head];
  for (genvar g = 0; g < N; g++) begin : g_split
    assign words[g] = head_blk[BLOCK_LENGTH-1-g*WORD_WIDTH -: WORD_WIDTH];
  end

  assign WORD_VALID = (state == STREAM);
  assign WORD_OUT   = WORD_VALID ? words[idx] : '0;
  assign LAST       = WORD_VALID && (idx == IW'(N-1));
  assign OVERFLOW   = ovf;
  assign LEVEL      = level;

  assign full = (level == LW'(FIFO_DEPTH));
  assign xfer = WORD_VALID && WORD_READY;
  assign pop  = xfer && LAST;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a block.
  assign push = IN_VALID && (!full || pop);
  assign drop = IN_VALID && full && !pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = STREAM;
      STREAM:  if (pop && level == LW'(1) && !push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      idx   <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (xfer) idx <= LAST ? '0 : idx + IW'(1);
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (CLR_OVF) ovf <= 1'b0;
    end
  end

  // Storage needs no reset: the output is gated by WORD_VALID and LEVEL tracks
  // which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= IN;
  end

endmodule

// File: tb/tb_cipher_out_serializer.sv
// Directed bench for cipher_out_serializer. Stimulus pushes the expected
// {last, word} sequence of each accepted block into a queue. A monitor pops
// the queue and compares on every transfer.
module tb_cipher_out_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         IN_VALID;
  logic [127:0] IN;
  logic         CLR_OVF;
  logic [31:0]  WORD_OUT;
  logic         WORD_VALID;
  logic         WORD_READY;
  logic         LAST;
  logic         OVERFLOW;
  logic [2:0]   LEVEL;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  logic [32:0] exp_q [$];

  cipher_out_serializer dut (
    .clk(clk), .rst(rst), .IN_VALID(IN_VALID), .IN(IN), .CLR_OVF(CLR_OVF),
    .WORD_OUT(WORD_OUT), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
    .LAST(LAST), .OVERFLOW(OVERFLOW), .LEVEL(LEVEL)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BA = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BB = 128'h10101010_20202020_30303030_40404040;
  localparam logic [127:0] BC = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  localparam logic [127:0] BD = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
  localparam logic [127:0] BE = 128'heeeeeeee_eeeeeeee_eeeeeeee_eeeeeeee;
  localparam logic [127:0] BF = 128'hf0f0f0f0_0f0f0f0f_12345678_9abcdef0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_blk(input logic [127:0] b);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({(i == 3), b[127-32*i -: 32]});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      step();
      n++;
    end
    chk(name, 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: sample mid-cycle, when the inputs for the coming edge are stable.
  always @(negedge clk) begin
    if (rst && WORD_VALID && WORD_READY) begin
      logic [32:0] e;
      xfers++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got %h/%0b expected none", WORD_OUT, LAST);
      end else begin
        e = exp_q.pop_front();
        if ({LAST, WORD_OUT} !== e) begin
          fails++;
          $display("FAIL stream_word: got %0b/%h expected %0b/%h",
                   LAST, WORD_OUT, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gaps, maxlvl, x0;
    rst = 1'b0; IN_VALID = 1'b0; IN = '0; CLR_OVF = 1'b0; WORD_READY = 1'b0;
    repeat (2) step();
    chk("rst_word", 128'(WORD_OUT), 0);
    chk("rst_valid", 128'(WORD_VALID), 0);
    chk("rst_last", 128'(LAST), 0);
    chk("rst_ovf", 128'(OVERFLOW), 0);
    chk("rst_level", 128'(LEVEL), 0);
    rst = 1'b1;
    step();

    // 1: FIPS-197 vector, with word 0 visible right after the push edge
    WORD_READY = 1'b1;
    IN_VALID = 1'b1; IN = FIPS; expect_blk(FIPS);
    step();
    IN_VALID = 1'b0; IN = '0;
    chk("t1_level1", 128'(LEVEL), 1);
    chk("t1_valid", 128'(WORD_VALID), 1);
    chk("t1_word0", 128'(WORD_OUT), 128'h69c4e0d8);
    repeat (4) step();
    chk("t1_valid_after", 128'(WORD_VALID), 0);
    chk("t1_level0", 128'(LEVEL), 0);

    // 2: back-pressure after two words
    IN_VALID = 1'b1; IN = FIPS; expect_blk(FIPS);
    step();
    IN_VALID = 1'b0;
    repeat (2) step();
    WORD_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_word", 128'(WORD_OUT), 128'hd8cdb780);
      chk("t2_hold_last", 128'(LAST), 0);
      step();
    end
    WORD_READY = 1'b1;
    repeat (2) step();
    chk("t2_valid_after", 128'(WORD_VALID), 0);

    // 3: fill with A..D; E is dropped
    WORD_READY = 1'b0;
    IN_VALID = 1'b1;
    IN = BA; expect_blk(BA); step();
    IN = BB; expect_blk(BB); step();
    IN = BC; expect_blk(BC); step();
    IN = BD; expect_blk(BD); step();
    IN = BE; step();
    IN_VALID = 1'b0;
    chk("t3_level_full", 128'(LEVEL), 4);
    chk("t3_ovf", 128'(OVERFLOW), 1);
    chk("t3_head_word", 128'(WORD_OUT), 128'h00112233);

    // 4: push F on the same edge that A's last word transfers
    WORD_READY = 1'b1;
    repeat (3) step();
    chk("t4_last_before", 128'(LAST), 1);
    chk("t4_level_before", 128'(LEVEL), 4);
    IN_VALID = 1'b1; IN = BF; expect_blk(BF);
    step();
    IN_VALID = 1'b0;
    chk("t4_level_kept", 128'(LEVEL), 4);
    chk("t4_ovf_kept", 128'(OVERFLOW), 1);
    drain("t34_drain");
    chk("t34_valid_after", 128'(WORD_VALID), 0);
    chk("t34_level0", 128'(LEVEL), 0);

    // 5: a block every 4th cycle gives a gap-free stream at LEVEL<=1
    gaps = 0; maxlvl = 0;
    for (int b = 0; b < 4; b++) begin
      IN_VALID = 1'b1;
      IN = (b % 2 == 0) ? BC : BF;
      expect_blk(IN);
      step();
      IN_VALID = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (!WORD_VALID) gaps++;
        if (int'(LEVEL) > maxlvl) maxlvl = int'(LEVEL);
        if (j < 3) step();
      end
    end
    step();
    chk("t5_gaps", 128'(gaps), 0);
    chk("t5_max_level", 128'(maxlvl), 1);
    chk("t5_valid_after", 128'(WORD_VALID), 0);
    chk("t5_ovf_before_clr", 128'(OVERFLOW), 1);
    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    chk("t5_ovf_cleared", 128'(OVERFLOW), 0);

    // 6: asynchronous reset partway through a 3-block backlog
    WORD_READY = 1'b0;
    IN_VALID = 1'b1;
    IN = BA; expect_blk(BA); step();
    IN = BB; expect_blk(BB); step();
    IN = BD; expect_blk(BD); step();
    IN_VALID = 1'b0;
    chk("t6_level3", 128'(LEVEL), 3);
    WORD_READY = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("t6_rst_word", 128'(WORD_OUT), 0);
    chk("t6_rst_valid", 128'(WORD_VALID), 0);
    chk("t6_rst_last", 128'(LAST), 0);
    chk("t6_rst_level", 128'(LEVEL), 0);
    chk("t6_rst_ovf", 128'(OVERFLOW), 0);
    exp_q.delete();
    repeat (2) step();
    rst = 1'b1;
    x0 = xfers;
    repeat (10) step();
    chk("t6_no_residual", 128'(xfers - x0), 0);
    chk("t6_valid_idle", 128'(WORD_VALID), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
